// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encoding constants, mnemonic codes and encoder FSM states.
package mips_pkg;

    typedef enum logic [3:0] {
        K_ADDU  = 4'd0,
        K_SUBU  = 4'd1,
        K_AND   = 4'd2,
        K_OR    = 4'd3,
        K_SLTU  = 4'd4,
        K_LW    = 4'd5,
        K_SW    = 4'd6,
        K_BEQ   = 4'd7,
        K_ADDIU = 4'd8,
        K_J     = 4'd9,
        K_NOP   = 4'd10,
        K_LI    = 4'd11,
        K_MOVE  = 4'd12
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SLOT = 1'b1
    } state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: combinational map from mnemonic code and fields to a machine word.
module instr_field_pack
    import mips_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        is_ctrl,
    output logic        invalid
);

    always_comb begin
        word    = '0;
        is_ctrl = 1'b0;
        invalid = 1'b0;
        case (kind)
            K_ADDU:  word = r_word(rs, rt, rd, FN_ADDU);
            K_SUBU:  word = r_word(rs, rt, rd, FN_SUBU);
            K_AND:   word = r_word(rs, rt, rd, FN_AND);
            K_OR:    word = r_word(rs, rt, rd, FN_OR);
            K_SLTU:  word = r_word(rs, rt, rd, FN_SLTU);
            K_LW:    word = i_word(OP_LW, rs, rt, imm[15:0]);
            K_SW:    word = i_word(OP_SW, rs, rt, imm[15:0]);
            K_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm[15:0]);
            K_BEQ: begin
                word    = i_word(OP_BEQ, rs, rt, imm[15:0]);
                is_ctrl = 1'b1;
            end
            K_J: begin
                word    = {OP_J, imm};
                is_ctrl = 1'b1;
            end
            K_NOP:   word = '0;
            K_LI:    word = i_word(OP_ADDIU, 5'd0, rt, imm[15:0]);
            K_MOVE:  word = r_word(rs, 5'd0, rd, FN_ADDU);
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS instruction encoder with word addresses and optional delay-slot NOPs.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int AW         = 8,
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_kind,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [25:0]   in_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_word,
    output logic [AW-1:0] out_addr,
    output logic          err
);

    state_e        state_q, state_d;
    logic          valid_q, valid_d;
    logic [31:0]   word_q, word_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          err_q, err_d;
    logic [31:0]   pack_word;
    logic          pack_ctrl, pack_invalid;
    logic          accept, load, out_hs, in_slot;

    instr_field_pack u_pack (
        .kind    (in_kind),
        .rd      (in_rd),
        .rs      (in_rs),
        .rt      (in_rt),
        .imm     (in_imm),
        .word    (pack_word),
        .is_ctrl (pack_ctrl),
        .invalid (pack_invalid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            word_q  <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        in_slot = state_q == S_SLOT;
        accept  = in_valid && in_ready;
        load    = accept && !pack_invalid;
        out_hs  = valid_q && out_ready;
        state_d = in_slot ? (out_hs ? S_IDLE : S_SLOT)
                          : ((load && pack_ctrl && DELAY_SLOT) ? S_SLOT : S_IDLE);
    end

    // SLOT always presents a word: first the branch, then the NOP that replaces it.
    always_comb begin
        valid_d = in_slot || load || (valid_q && !out_ready);
        word_d  = load ? pack_word : ((in_slot && out_hs) ? '0 : word_q);
        err_d   = accept && pack_invalid;
        addr_d  = (clear_addr && !in_slot) ? '0 : (out_hs ? addr_q + 1'b1 : addr_q);
    end

    always_comb begin
        in_ready  = !in_slot && (!valid_q || out_ready);
        out_valid = valid_q;
        out_word  = word_q;
        out_addr  = addr_q;
        err       = err_q;
    end

endmodule
